// File: rtl/rps_pkg.sv
// Shared encodings, FSM states and LFSR tap masks for the rock-paper-scissors match block.
package rps_pkg;

  localparam logic [1:0] MV_ROCK     = 2'b00;
  localparam logic [1:0] MV_PAPER    = 2'b01;
  localparam logic [1:0] MV_ILLEGAL  = 2'b10;
  localparam logic [1:0] MV_SCISSORS = 2'b11;

  localparam logic [1:0] RES_USER    = 2'b00;
  localparam logic [1:0] RES_DRAW    = 2'b01;
  localparam logic [1:0] RES_ILLEGAL = 2'b10;
  localparam logic [1:0] RES_CPU     = 2'b11;

  // Tap masks: bit i set means state bit i feeds the XOR (x^8+x^6+x^5+x^4+1, x^16+x^14+x^13+x^11+1)
  localparam logic [15:0] LFSR_TAPS_8  = 16'h00B8;
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCORE = 2'd1,
    ST_OVER  = 2'd2
  } state_e;

  function automatic logic [15:0] lfsr_taps(input int unsigned w);
    return (w == 16) ? LFSR_TAPS_16 : LFSR_TAPS_8;
  endfunction

  // The illegal code never becomes a computer move: try the next pair, then fall back to rock.
  function automatic logic [1:0] cpu_pick(input logic [3:0] bits);
    if (bits[1:0] != MV_ILLEGAL) return bits[1:0];
    if (bits[3:2] != MV_ILLEGAL) return bits[3:2];
    return MV_ROCK;
  endfunction

  function automatic logic [1:0] rps_judge(input logic [1:0] user, input logic [1:0] cpu);
    if (user == MV_ILLEGAL) return RES_ILLEGAL;
    if (user == cpu) return RES_DRAW;
    if ((user == MV_ROCK     && cpu == MV_SCISSORS) ||
        (user == MV_PAPER    && cpu == MV_ROCK)     ||
        (user == MV_SCISSORS && cpu == MV_PAPER))
      return RES_USER;
    return RES_CPU;
  endfunction

endpackage

// File: rtl/lfsr_n.sv
// Free-running Fibonacci LFSR (8 or 16 bits); shifts toward the MSB with feedback into bit 0.
module lfsr_n
  import rps_pkg::*;
#(
  parameter int unsigned     W    = 8,
  parameter logic [W-1:0]    SEED = W'(8'hA5)
) (
  input  logic         clk,
  input  logic         reset,
  output logic [W-1:0] state_o
);

  localparam logic [W-1:0] TAPS     = W'(lfsr_taps(W));
  // An all-zero state would lock up the register.
  localparam logic [W-1:0] SEED_EFF = (SEED == '0) ? W'(1) : SEED;

  logic [W-1:0] lfsr_q;
  logic [W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[W-2:0], ^(lfsr_q & TAPS)};
  end

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= SEED_EFF;
    else       lfsr_q <= lfsr_d;
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/rps_match.sv
// Rock-paper-scissors match controller: accepts user moves, plays an LFSR opponent, keeps score.
//   state | meaning
//   IDLE  | waiting for a move or a new_match request
//   SCORE | result strobe cycle; scores update on exit
//   OVER  | match decided, moves ignored until new_match
module rps_match
  import rps_pkg::*;
#(
  parameter int unsigned          LFSR_W        = 8,
  parameter logic [LFSR_W-1:0]    SEED          = LFSR_W'(8'hA5),
  parameter int unsigned          ROUNDS_TO_WIN = 3,
  parameter int unsigned          SCORE_W       = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               move_valid,
  input  logic [1:0]         move,
  input  logic               new_match,
  output logic               move_ready,
  output logic               result_valid,
  output logic [1:0]         result,
  output logic [1:0]         cpu_move,
  output logic [SCORE_W-1:0] user_score,
  output logic [SCORE_W-1:0] cpu_score,
  output logic               match_over,
  output logic               match_winner
);

  localparam logic [SCORE_W-1:0] WIN_CNT = SCORE_W'(ROUNDS_TO_WIN);

  state_e             state_q;
  logic               rv_q;
  logic [1:0]         result_q;
  logic [1:0]         cpu_move_q;
  logic [SCORE_W-1:0] user_score_q;
  logic [SCORE_W-1:0] cpu_score_q;
  logic               over_q;
  logic               winner_q;

  logic [LFSR_W-1:0]  lfsr_state;
  logic               lfsr_unused;
  logic [1:0]         cpu_pick_d;
  logic [1:0]         judge_d;
  logic [SCORE_W-1:0] user_inc_d;
  logic [SCORE_W-1:0] cpu_inc_d;

  lfsr_n #(
    .W    (LFSR_W),
    .SEED (SEED)
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .state_o (lfsr_state)
  );

  assign lfsr_unused = ^lfsr_state[LFSR_W-1:4];

  always_comb begin
    cpu_pick_d = cpu_pick(lfsr_state[3:0]);
    judge_d    = rps_judge(move, cpu_pick_d);
    user_inc_d = user_score_q + SCORE_W'(1);
    cpu_inc_d  = cpu_score_q + SCORE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rv_q         <= 1'b0;
      result_q     <= '0;
      cpu_move_q   <= '0;
      user_score_q <= '0;
      cpu_score_q  <= '0;
      over_q       <= 1'b0;
      winner_q     <= 1'b0;
    end else begin
      rv_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (new_match) begin
            user_score_q <= '0;
            cpu_score_q  <= '0;
            over_q       <= 1'b0;
            winner_q     <= 1'b0;
          end else if (move_valid) begin
            state_q    <= ST_SCORE;
            cpu_move_q <= cpu_pick_d;
            result_q   <= judge_d;
            rv_q       <= 1'b1;
          end
        end
        ST_SCORE: begin
          state_q <= ST_IDLE;
          if (result_q == RES_USER) begin
            user_score_q <= user_inc_d;
            if (user_inc_d == WIN_CNT) begin
              state_q  <= ST_OVER;
              over_q   <= 1'b1;
              winner_q <= 1'b0;
            end
          end else if (result_q == RES_CPU) begin
            cpu_score_q <= cpu_inc_d;
            if (cpu_inc_d == WIN_CNT) begin
              state_q  <= ST_OVER;
              over_q   <= 1'b1;
              winner_q <= 1'b1;
            end
          end
        end
        ST_OVER: begin
          if (new_match) begin
            state_q      <= ST_IDLE;
            user_score_q <= '0;
            cpu_score_q  <= '0;
            over_q       <= 1'b0;
            winner_q     <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign move_ready   = (state_q == ST_IDLE) && !new_match && !reset;
  // Gated so a reset landing on the SCORE cycle suppresses the strobe already in flight.
  assign result_valid = rv_q && !reset;
  assign result       = result_q;
  assign cpu_move     = cpu_move_q;
  assign user_score   = user_score_q;
  assign cpu_score    = cpu_score_q;
  assign match_over   = over_q;
  assign match_winner = winner_q;

endmodule

// File: doc/rps_match.md
RPS_MATCH -- requirements
Module: rps_match

Interface
REQ-001 SHALL have parameter LFSR_W, default 8, width of the opponent LFSR; legal values are 8 and 16.
REQ-002 SHALL have parameter SEED, default 8'hA5, LFSR reset value; zero is replaced by 1.
REQ-003 SHALL have parameter ROUNDS_TO_WIN, default 3, round wins that end a match; range 1 to 2^SCORE_W-1.
REQ-004 SHALL have parameter SCORE_W, default 4, width of the score counters.
REQ-005 SHALL have one clock; reset is synchronous and active-high. Ports clk and reset.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 move_valid  in  1  user move offered.
REQ-009 move  in  2  user move: 00 rock, 01 paper, 11 scissors, 10 illegal.
REQ-010 new_match  in  1  clear scores and start a new match.
REQ-011 move_ready  out  1  block accepts a move this cycle.
REQ-012 result_valid  out  1  one-cycle strobe marking a round result.
REQ-013 result  out  2  00 user wins, 01 draw, 11 computer wins, 10 illegal move.
REQ-014 cpu_move  out  2  computer move for the reported round.
REQ-015 user_score, cpu_score  out  SCORE_W each  round wins in the current match.
REQ-016 match_over  out  1  match decided.
REQ-017 match_winner  out  1  0 user, 1 computer; valid while match_over=1.

Function
REQ-018 The FSM SHALL have three states: IDLE, SCORE and OVER.
REQ-019 move_ready SHALL be (state==IDLE && !new_match && !reset).
REQ-020 A move SHALL be accepted on an edge where move_valid && move_ready; on that edge the FSM goes IDLE->SCORE and latches move and cpu_move.
REQ-021 cpu_move SHALL be taken from LFSR bits [1:0] on the accept edge, with 10 remapped to LFSR bits [3:2], and 10 again remapped to 00.
REQ-022 The LFSR SHALL be Fibonacci, maximal-length, and advance every cycle regardless of FSM state.
REQ-023 In SCORE, result_valid SHALL be 1 for exactly one cycle, with result set by the standard rock-paper-scissors rules; latency is accept edge +1 cycle.
REQ-024 On the SCORE exit edge, the winner's score SHALL increment by 1; draws and illegal moves leave both scores unchanged.
REQ-025 If either score equals ROUNDS_TO_WIN after the update, the next state SHALL be OVER with match_over=1 and match_winner set; otherwise the next state is IDLE.
REQ-026 In OVER, move_valid SHALL be ignored, and match_over and the scores hold until new_match or reset.
REQ-027 new_match in IDLE or OVER SHALL clear scores, match_over and match_winner on the next edge, and the next state is IDLE.
REQ-028 new_match in SCORE SHALL be ignored.
REQ-029 When new_match and move_valid are high together in IDLE, new_match SHALL win and no move is accepted.
REQ-030 Maximum throughput SHALL be one move per 2 cycles.

Reset
REQ-031 While reset is high, move_ready SHALL be 0.
REQ-032 On a reset edge: state=IDLE, LFSR=SEED, and result_valid, result, cpu_move, both scores, match_over and match_winner SHALL all be 0.
REQ-033 Reset in any state, including mid-SCORE, SHALL abort without emitting result_valid.

Structure
REQ-034 Package rps_pkg SHALL hold the move and result encodings, the state enum, and the LFSR tap constants (8: x^8+x^6+x^5+x^4+1; 16: x^16+x^14+x^13+x^11+1).
REQ-035 The LFSR SHALL be sub-module lfsr_n, parameterised by width and seed, outputting its full state.

Verification
REQ-036 Reset held 2 cycles -> all outputs 0 and move_ready=0; move_ready=1 on the first cycle after release.
REQ-037 All 9 legal pairings, checked against cpu_move -> e.g. user 00 vs cpu 11 gives result 00, user 01 vs 11 gives 11, user 11 vs 11 gives 01; result_valid exactly 1 cycle after accept.
REQ-038 move=10 -> result=10, scores unchanged, FSM back in IDLE.
REQ-039 ROUNDS_TO_WIN=3 with 3 user wins -> user_score=3, match_over=1, match_winner=0; further move_valid gets no result; new_match -> scores 0 and move_ready=1 next cycle.
REQ-040 new_match and move_valid together in IDLE -> no result_valid and scores 0.
REQ-041 reset on the SCORE cycle -> result_valid=0 on every following cycle and scores 0.
